// File: rtl/rx_udp_port_demux_pkg.sv
// Shared constants and state encoding for the multi-channel UDP receive demux.
// The RX byte stream is steered per frame into per-channel frame-atomic FIFOs.
package rx_udp_port_demux_pkg;

  localparam int RX_OCT    = 8;
  localparam int RX_PORT_W = 16;

  localparam logic [7:0]  ETH_PRE        = 8'h55;
  localparam logic [7:0]  ETH_SFD        = 8'hD5;
  localparam logic [15:0] ETH_TYPE_IPV4  = 16'h0800;
  localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
  localparam logic [7:0]  IPV4_PROTO_UDP = 8'h11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DROP    = 2'd2,
    ST_NOMATCH = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rx_udp_port_demux_fifo.sv
// Frame-atomic byte FIFO: bytes become visible to the reader only on commit,
// and a rollback discards everything written since the last commit.
module rx_frame_fifo
  import rx_udp_port_demux_pkg::*;
#(
  parameter int OCT   = RX_OCT,
  parameter int DEPTH = 2048
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [OCT-1:0] wr_data,
  input  logic           commit,
  input  logic           rollback,
  input  logic           rd_en,
  output logic [OCT-1:0] rd_data,
  output logic           empty,
  output logic           full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(32'd1);
  localparam logic [AW:0] PTR_DEPTH = (AW+1)'(DEPTH);

  logic [OCT-1:0] mem_r [DEPTH];
  logic [AW:0]    wptr_r;
  logic [AW:0]    cwptr_r;
  logic [AW:0]    rptr_r;
  logic [OCT-1:0] rd_data_r;
  logic           rd_ok_s;

  // Full uses the live read pointer, so a read frees space from the next cycle.
  assign full    = ((wptr_r - rptr_r) == PTR_DEPTH);
  assign empty   = (rptr_r == cwptr_r);
  assign rd_ok_s = rd_en & ~empty;
  assign rd_data = rd_data_r;

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Working, committed and read pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r  <= '0;
      cwptr_r <= '0;
      rptr_r  <= '0;
    end else begin
      if (rollback) begin
        wptr_r <= cwptr_r;
      end else if (wr_en) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (commit) begin
        cwptr_r <= wptr_r;
      end
      if (rd_ok_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
    end
  end

  // Registered read port; data holds when the read is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= '0;
    end else if (rd_ok_s) begin
      rd_data_r <= mem_r[rptr_r[AW-1:0]];
    end
  end

endmodule

// File: rtl/rx_udp_port_demux.sv
// Steers UDP payload frames into one of NCH frame-atomic FIFOs selected by
// destination port; raises commit/drop/no-match pulses one cycle after the decision.
module rx_udp_port_demux
  import rx_udp_port_demux_pkg::*;
#(
  parameter int OCT    = RX_OCT,
  parameter int NCH    = 4,
  parameter int DEPTH  = 2048,
  parameter int PORT_W = RX_PORT_W
) (
  input  logic                  RX_CLK,
  input  logic                  rst,
  input  logic [NCH*PORT_W-1:0] ch_port,
  input  logic [NCH-1:0]        ch_en,
  input  logic [PORT_W-1:0]     rx_dst_port,
  input  logic                  rx_udp_data_v,
  input  logic [OCT-1:0]        rx_udp_data,
  input  logic                  rx_abort,
  input  logic [NCH-1:0]        ch_rd_en,
  output logic [NCH*OCT-1:0]    ch_rd_data,
  output logic [NCH-1:0]        ch_empty,
  output logic [NCH-1:0]        ch_irq,
  output logic [NCH-1:0]        ch_drop,
  output logic                  rx_drop_nomatch
);

  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

  rx_state_e      state_r;
  rx_state_e      state_next_s;
  logic           valid_q_r;
  logic [SW-1:0]  sel_r;
  logic [SW-1:0]  sel_next_s;
  logic [SW-1:0]  match_idx_s;
  logic           match_found_s;
  logic [SW-1:0]  tgt_s;
  logic [NCH-1:0] tgt_onehot_s;
  logic           start_s;
  logic           end_s;
  logic           wr_s;
  logic           commit_s;
  logic           rollback_s;
  logic           irq_set_s;
  logic           drop_set_s;
  logic           nm_set_s;
  logic [NCH-1:0] fifo_full_s;
  logic [NCH-1:0] fifo_empty_s;
  logic [NCH-1:0] wr_en_s;
  logic [NCH-1:0] commit_en_s;
  logic [NCH-1:0] rollback_en_s;
  logic [NCH-1:0] ch_irq_r;
  logic [NCH-1:0] ch_drop_r;
  logic           nomatch_r;

  // valid_q resets high so a frame already running at reset release never starts.
  assign start_s = rx_udp_data_v & ~valid_q_r;
  assign end_s   = ~rx_udp_data_v & valid_q_r;

  // Lowest-numbered enabled channel whose port matches wins.
  always_comb begin
    match_found_s = 1'b0;
    match_idx_s   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_en[i] && (ch_port[i*PORT_W +: PORT_W] == rx_dst_port)) begin
        match_found_s = 1'b1;
        match_idx_s   = SW'(i);
      end else begin
        match_found_s = match_found_s;
      end
    end
  end

  // Channel targeted this cycle: fresh match on the first byte, latched select after.
  always_comb begin
    if (state_r == ST_IDLE) begin
      tgt_s = match_idx_s;
    end else begin
      tgt_s = sel_r;
    end
    tgt_onehot_s = NCH'(32'd1) << tgt_s;
  end

  // Next-state and per-frame write/commit/rollback decisions.
  always_comb begin
    state_next_s = state_r;
    sel_next_s   = sel_r;
    wr_s         = 1'b0;
    commit_s     = 1'b0;
    rollback_s   = 1'b0;
    irq_set_s    = 1'b0;
    drop_set_s   = 1'b0;
    nm_set_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          if (match_found_s) begin
            sel_next_s = match_idx_s;
            if (fifo_full_s[match_idx_s]) begin
              drop_set_s   = 1'b1;
              state_next_s = ST_DROP;
            end else begin
              wr_s         = 1'b1;
              state_next_s = ST_RECV;
            end
          end else begin
            state_next_s = ST_NOMATCH;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (rx_abort) begin
          rollback_s   = 1'b1;
          drop_set_s   = 1'b1;
          state_next_s = ST_DROP;
        end else if (rx_udp_data_v) begin
          if (fifo_full_s[sel_r]) begin
            rollback_s   = 1'b1;
            drop_set_s   = 1'b1;
            state_next_s = ST_DROP;
          end else begin
            wr_s = 1'b1;
          end
        end else if (end_s) begin
          commit_s     = 1'b1;
          irq_set_s    = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          rollback_s   = 1'b1;
          state_next_s = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (end_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DROP;
        end
      end
      ST_NOMATCH: begin
        if (end_s) begin
          nm_set_s     = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_NOMATCH;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  assign wr_en_s       = wr_s       ? tgt_onehot_s : '0;
  assign commit_en_s   = commit_s   ? tgt_onehot_s : '0;
  assign rollback_en_s = rollback_s ? tgt_onehot_s : '0;

  // FSM state, latched channel select and valid history.
  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      sel_r     <= '0;
      valid_q_r <= 1'b1;
    end else begin
      state_r   <= state_next_s;
      sel_r     <= sel_next_s;
      valid_q_r <= rx_udp_data_v;
    end
  end

  // One-cycle status pulses.
  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      ch_irq_r  <= '0;
      ch_drop_r <= '0;
      nomatch_r <= 1'b0;
    end else begin
      ch_irq_r  <= irq_set_s  ? tgt_onehot_s : '0;
      ch_drop_r <= drop_set_s ? tgt_onehot_s : '0;
      nomatch_r <= nm_set_s;
    end
  end

  assign ch_irq          = ch_irq_r;
  assign ch_drop         = ch_drop_r;
  assign rx_drop_nomatch = nomatch_r;
  assign ch_empty        = fifo_empty_s;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    rx_frame_fifo #(
      .OCT   (OCT),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (RX_CLK),
      .rst      (rst),
      .wr_en    (wr_en_s[g]),
      .wr_data  (rx_udp_data),
      .commit   (commit_en_s[g]),
      .rollback (rollback_en_s[g]),
      .rd_en    (ch_rd_en[g]),
      .rd_data  (ch_rd_data[g*OCT +: OCT]),
      .empty    (fifo_empty_s[g]),
      .full     (fifo_full_s[g])
    );
  end

endmodule

// File: tb/tb_rx_udp_port_demux.sv
// Directed bench for rx_udp_port_demux (NCH=4, DEPTH=16): a frame vector table
// plus hand-written sequences for pulse timing, abort/overflow and mid-frame reset.
module tb_rx_udp_port_demux;

  localparam int OCT    = 8;
  localparam int NCH    = 4;
  localparam int DEPTH  = 16;
  localparam int PORT_W = 16;

  logic                  RX_CLK = 1'b0;
  logic                  rst    = 1'b1;
  logic [NCH*PORT_W-1:0] ch_port;
  logic [NCH-1:0]        ch_en;
  logic [PORT_W-1:0]     rx_dst_port;
  logic                  rx_udp_data_v;
  logic [OCT-1:0]        rx_udp_data;
  logic                  rx_abort;
  logic [NCH-1:0]        ch_rd_en;
  logic [NCH*OCT-1:0]    ch_rd_data;
  logic [NCH-1:0]        ch_empty;
  logic [NCH-1:0]        ch_irq;
  logic [NCH-1:0]        ch_drop;
  logic                  rx_drop_nomatch;

  rx_udp_port_demux #(
    .OCT    (OCT),
    .NCH    (NCH),
    .DEPTH  (DEPTH),
    .PORT_W (PORT_W)
  ) dut (
    .RX_CLK          (RX_CLK),
    .rst             (rst),
    .ch_port         (ch_port),
    .ch_en           (ch_en),
    .rx_dst_port     (rx_dst_port),
    .rx_udp_data_v   (rx_udp_data_v),
    .rx_udp_data     (rx_udp_data),
    .rx_abort        (rx_abort),
    .ch_rd_en        (ch_rd_en),
    .ch_rd_data      (ch_rd_data),
    .ch_empty        (ch_empty),
    .ch_irq          (ch_irq),
    .ch_drop         (ch_drop),
    .rx_drop_nomatch (rx_drop_nomatch)
  );

  always #5 RX_CLK = ~RX_CLK;

  typedef struct {
    logic [63:0] ports;
    logic [3:0]  en;
    logic [15:0] dport;
    int          len;
    logic [7:0]  base;
    int          abort_at;
    logic [3:0]  e_irq;
    logic [3:0]  e_drop;
    logic        e_nm;
    logic [3:0]  e_empty;
    int          rd_ch;
    int          rd_n;
  } vec_t;

  vec_t vecs [9];

  int errors = 0;
  int checks = 0;
  int irq_cnt  [NCH] = '{default: 0};
  int drop_cnt [NCH] = '{default: 0};
  int nm_cnt = 0;
  int irq_b  [NCH];
  int drop_b [NCH];
  int nm_b;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge RX_CLK) begin
    for (int i = 0; i < NCH; i++) begin
      if (ch_irq[i])  irq_cnt[i]  <= irq_cnt[i] + 1;
      if (ch_drop[i]) drop_cnt[i] <= drop_cnt[i] + 1;
    end
    if (rx_drop_nomatch) nm_cnt <= nm_cnt + 1;
  end

  function automatic logic [63:0] pk(input logic [15:0] p3, input logic [15:0] p2,
                                     input logic [15:0] p1, input logic [15:0] p0);
    return {p3, p2, p1, p0};
  endfunction

  // Expected pulse counts: one nibble per channel, 1 where a single pulse is due.
  function automatic logic [15:0] expand(input logic [3:0] m);
    logic [15:0] r;
    for (int i = 0; i < NCH; i++) r[i*4 +: 4] = {3'b000, m[i]};
    return r;
  endfunction

  function automatic logic [15:0] irq_diff();
    logic [15:0] r;
    for (int i = 0; i < NCH; i++) r[i*4 +: 4] = 4'(irq_cnt[i] - irq_b[i]);
    return r;
  endfunction

  function automatic logic [15:0] drop_diff();
    logic [15:0] r;
    for (int i = 0; i < NCH; i++) r[i*4 +: 4] = 4'(drop_cnt[i] - drop_b[i]);
    return r;
  endfunction

  task automatic snap();
    for (int i = 0; i < NCH; i++) begin
      irq_b[i]  = irq_cnt[i];
      drop_b[i] = drop_cnt[i];
    end
    nm_b = nm_cnt;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge RX_CLK);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] dport, input int len,
                            input logic [7:0] base, input int abort_at);
    for (int k = 0; k < len; k++) begin
      tick();
      rx_udp_data_v = 1'b1;
      rx_udp_data   = base + 8'(k);
      rx_dst_port   = dport;
      rx_abort      = (abort_at == k + 1);
    end
    tick();
    rx_udp_data_v = 1'b0;
    rx_abort      = 1'b0;
  endtask

  task automatic read_byte(input int ch, input logic [7:0] exp, input string name);
    tick();
    ch_rd_en[ch] = 1'b1;
    tick();
    ch_rd_en = '0;
    check(name, {24'd0, ch_rd_data[ch*OCT +: OCT]}, {24'd0, exp});
  endtask

  task automatic check_pulses(input string name, input logic [3:0] e_irq,
                              input logic [3:0] e_drop, input logic e_nm);
    check({name, " irq"},  {16'd0, irq_diff()},  {16'd0, expand(e_irq)});
    check({name, " drop"}, {16'd0, drop_diff()}, {16'd0, expand(e_drop)});
    check({name, " nomatch"}, 32'(nm_cnt - nm_b), {31'd0, e_nm});
  endtask

  initial begin
    ch_port       = '0;
    ch_en         = '0;
    rx_dst_port   = '0;
    rx_udp_data_v = 1'b0;
    rx_udp_data   = '0;
    rx_abort      = 1'b0;
    ch_rd_en      = '0;

    vecs[0] = '{pk(16'd0, 16'd0, 16'd0, 16'd5353), 4'b0001, 16'd5353, 10, 8'h00, 0,
                4'b0001, 4'b0000, 1'b0, 4'b1110, 0, 10};
    vecs[1] = '{pk(16'd0, 16'd0, 16'd0, 16'd5353), 4'b0001, 16'd80, 6, 8'h20, 0,
                4'b0000, 4'b0000, 1'b1, 4'b1111, 0, 0};
    vecs[2] = '{pk(16'd0, 16'd0, 16'd0, 16'd5353), 4'b0001, 16'd5353, 17, 8'h40, 0,
                4'b0000, 4'b0001, 1'b0, 4'b1111, 0, 0};
    vecs[3] = '{pk(16'd0, 16'd0, 16'd0, 16'd5353), 4'b0001, 16'd5353, 16, 8'h60, 0,
                4'b0001, 4'b0000, 1'b0, 4'b1110, 0, 16};
    vecs[4] = '{pk(16'd0, 16'd1000, 16'd1000, 16'd5353), 4'b0111, 16'd1000, 5, 8'h80, 0,
                4'b0010, 4'b0000, 1'b0, 4'b1101, 1, 5};
    vecs[5] = '{pk(16'd7, 16'd1000, 16'd1000, 16'd5353), 4'b1110, 16'd5353, 4, 8'h90, 0,
                4'b0000, 4'b0000, 1'b1, 4'b1111, 0, 0};
    vecs[6] = '{pk(16'd7, 16'd1000, 16'd1000, 16'd5353), 4'b1110, 16'd7, 3, 8'hA0, 0,
                4'b1000, 4'b0000, 1'b0, 4'b0111, 3, 3};
    vecs[7] = '{pk(16'd7, 16'd1000, 16'd1000, 16'd5353), 4'b1110, 16'd1000, 6, 8'hB0, 3,
                4'b0000, 4'b0010, 1'b0, 4'b1111, 0, 0};
    vecs[8] = '{pk(16'd7, 16'd1000, 16'd1000, 16'd5353), 4'b1110, 16'd1000, 1, 8'hC0, 0,
                4'b0010, 4'b0000, 1'b0, 4'b1101, 1, 1};

    // Reset state
    repeat (2) tick();
    check("reset empty", {28'd0, ch_empty}, 32'h0000000F);
    check("reset irq",   {28'd0, ch_irq},   32'h00000000);
    check("reset drop",  {28'd0, ch_drop},  32'h00000000);
    check("reset nomatch", {31'd0, rx_drop_nomatch}, 32'h00000000);
    check("reset rd_data", ch_rd_data, 32'h00000000);
    rst = 1'b0;
    repeat (2) tick();

    // Table-driven frames
    for (int v = 0; v < 9; v++) begin
      ch_port = vecs[v].ports;
      ch_en   = vecs[v].en;
      snap();
      send_frame(vecs[v].dport, vecs[v].len, vecs[v].base, vecs[v].abort_at);
      repeat (3) tick();
      check_pulses($sformatf("vec%0d", v), vecs[v].e_irq, vecs[v].e_drop, vecs[v].e_nm);
      check($sformatf("vec%0d empty", v), {28'd0, ch_empty}, {28'd0, vecs[v].e_empty});
      for (int k = 0; k < vecs[v].rd_n; k++) begin
        read_byte(vecs[v].rd_ch, vecs[v].base + 8'(k), $sformatf("vec%0d byte%0d", v, k));
      end
      check($sformatf("vec%0d drained", v), {28'd0, ch_empty}, 32'h0000000F);
    end

    // Exact irq timing and empty transition, then read on empty holds data
    ch_port = pk(16'd0, 16'd0, 16'd0, 16'd5353);
    ch_en   = 4'b0001;
    send_frame(16'd5353, 2, 8'hE0, 0);
    check("timing irq before", {28'd0, ch_irq}, 32'h00000000);
    check("timing empty before", {31'd0, ch_empty[0]}, 32'h00000001);
    tick();
    check("timing irq pulse", {28'd0, ch_irq}, 32'h00000001);
    check("timing empty after", {31'd0, ch_empty[0]}, 32'h00000000);
    tick();
    check("timing irq cleared", {28'd0, ch_irq}, 32'h00000000);
    read_byte(0, 8'hE0, "timing byte0");
    read_byte(0, 8'hE1, "timing byte1");
    read_byte(0, 8'hE1, "read on empty holds");
    check("read on empty stays empty", {31'd0, ch_empty[0]}, 32'h00000001);

    // Commit A, abort B, overflow C with A unread
    snap();
    send_frame(16'd5353, 4, 8'h10, 0);
    repeat (3) tick();
    check_pulses("frame A", 4'b0001, 4'b0000, 1'b0);
    snap();
    send_frame(16'd5353, 8, 8'h30, 5);
    repeat (3) tick();
    check_pulses("abort B", 4'b0000, 4'b0001, 1'b0);
    snap();
    send_frame(16'd5353, 13, 8'h50, 0);
    repeat (3) tick();
    check_pulses("overflow C", 4'b0000, 4'b0001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      read_byte(0, 8'h10 + 8'(k), $sformatf("frame A byte%0d", k));
    end
    check("frame A drained", {31'd0, ch_empty[0]}, 32'h00000001);

    // Reset during the third byte, released with valid still high
    snap();
    for (int k = 0; k < 6; k++) begin
      tick();
      rx_udp_data_v = 1'b1;
      rx_udp_data   = 8'h70 + 8'(k);
      rx_dst_port   = 16'd5353;
      if (k == 2) rst = 1'b1;
      if (k == 3) rst = 1'b0;
    end
    tick();
    rx_udp_data_v = 1'b0;
    repeat (3) tick();
    check_pulses("midreset", 4'b0000, 4'b0000, 1'b0);
    check("midreset empty", {28'd0, ch_empty}, 32'h0000000F);
    snap();
    send_frame(16'd5353, 4, 8'h90, 0);
    repeat (3) tick();
    check_pulses("post reset", 4'b0001, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      read_byte(0, 8'h90 + 8'(k), $sformatf("post reset byte%0d", k));
    end
    check("post reset drained", {28'd0, ch_empty}, 32'h0000000F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
